// File: rtl/fp_addsub_unit.sv
// Multi-cycle floating-point add/subtract unit: IDLE -> ALIGN -> ADD -> NORM.
// Round to nearest even, subnormals supported, canonical quiet NaN output.
module fp_addsub_unit #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Sub,
  input  logic [TAG_W-1:0]       Tag,
  input  logic [EXP_W+MAN_W:0]   Operand1,
  input  logic [EXP_W+MAN_W:0]   Operand2,
  output logic [EXP_W+MAN_W:0]   Result,
  output logic [TAG_W-1:0]       ResultTag,
  output logic [2:0]             Flags,
  output logic                   Busy,
  output logic                   Done
);

  localparam int unsigned W       = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W   = MAN_W + 1;
  localparam int unsigned EXT_W   = SIG_W + 3;
  localparam int unsigned SUM_W   = EXT_W + 1;
  localparam int unsigned XE_W    = EXP_W + 1;
  localparam int unsigned LZ_W    = $clog2(EXT_W + 1);
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;

  state_t             state;
  logic [W-1:0]       op_a, op_b;
  logic               sub_q;
  logic [TAG_W-1:0]   tag_q;

  logic               al_sign, al_sub;
  logic [EXP_W-1:0]   al_exp;
  logic [EXT_W-1:0]   al_big, al_small;
  logic               sp_valid, sp_inv;
  logic [W-1:0]       sp_res;

  logic [SUM_W-1:0]   ad_sum;
  logic               ad_sign;

  // Unpack the captured operands; Operand2 sign flips for subtraction
  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp, a_xe, b_xe;
  logic [MAN_W-1:0]   a_frac, b_frac;
  logic [SIG_W-1:0]   a_sig, b_sig;
  logic               a_nan, b_nan, a_inf, b_inf, a_ge;

  assign a_sign = op_a[W-1];
  assign b_sign = op_b[W-1] ^ sub_q;
  assign a_exp  = op_a[W-2:MAN_W];
  assign b_exp  = op_b[W-2:MAN_W];
  assign a_frac = op_a[MAN_W-1:0];
  assign b_frac = op_b[MAN_W-1:0];
  assign a_xe   = (a_exp == '0) ? EXP_W'(1) : a_exp;
  assign b_xe   = (b_exp == '0) ? EXP_W'(1) : b_exp;
  assign a_sig  = {(a_exp != '0), a_frac};
  assign b_sig  = {(b_exp != '0), b_frac};
  assign a_nan  = (a_exp == '1) && (a_frac != '0);
  assign b_nan  = (b_exp == '1) && (b_frac != '0);
  assign a_inf  = (a_exp == '1) && (a_frac == '0);
  assign b_inf  = (b_exp == '1) && (b_frac == '0);
  assign a_ge   = (op_a[W-2:0] >= op_b[W-2:0]);

  // ALIGN: order by magnitude, shift the smaller significand with guard/round/sticky
  logic               nx_sign;
  logic [EXP_W-1:0]   nx_exp, s_exp, e_diff;
  logic [SIG_W-1:0]   l_sig, s_sig;
  logic [SIG_W+1:0]   s_tmp, s_top, s_lost;
  logic               nx_sp_valid, nx_sp_inv;
  logic [W-1:0]       nx_sp_res;

  always_comb begin
    nx_sign     = a_ge ? a_sign : b_sign;
    nx_exp      = a_ge ? a_xe   : b_xe;
    s_exp       = a_ge ? b_xe   : a_xe;
    l_sig       = a_ge ? a_sig  : b_sig;
    s_sig       = a_ge ? b_sig  : a_sig;
    e_diff      = nx_exp - s_exp;
    s_tmp       = {s_sig, 2'b00};
    s_top       = s_tmp >> e_diff;
    s_lost      = s_tmp & ~({(SIG_W+2){1'b1}} << e_diff);
    nx_sp_valid = a_nan | b_nan | a_inf | b_inf;
    nx_sp_inv   = 1'b0;
    nx_sp_res   = QNAN;
    if (a_nan || b_nan) begin
      nx_sp_res = QNAN;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      nx_sp_res = QNAN;
      nx_sp_inv = 1'b1;
    end else if (a_inf) begin
      nx_sp_res = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      nx_sp_res = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // ADD: magnitude add or subtract; exact cancellation yields +0
  logic [SUM_W-1:0]   nx_sum;
  logic               nx_sum_sign;

  always_comb begin
    if (al_sub) nx_sum = {1'b0, al_big} - {1'b0, al_small};
    else        nx_sum = {1'b0, al_big} + {1'b0, al_small};
    nx_sum_sign = (al_sub && (nx_sum == '0)) ? 1'b0 : al_sign;
  end

  // NORM: leading-zero count of the non-carry sum
  logic [LZ_W-1:0]    lzc;

  always_comb begin
    lzc = LZ_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (ad_sum[i]) lzc = LZ_W'(EXT_W - 1 - i);
    end
  end

  // NORM: normalise, round to nearest even, encode specials and overflow
  logic [EXT_W-1:0]   nm_sig;
  logic [XE_W-1:0]    nm_exp, e_room, e_fin;
  int unsigned        sh;
  logic               rnd_up, inexact;
  logic [SIG_W:0]     rnd;
  logic [MAN_W-1:0]   frac_fin;
  logic [W-1:0]       nx_res;
  logic [2:0]         nx_flags;

  always_comb begin
    e_room   = {1'b0, al_exp} - XE_W'(1);
    sh       = 0;
    nm_sig   = ad_sum[EXT_W-1:0];
    nm_exp   = {1'b0, al_exp};
    if (ad_sum[EXT_W]) begin
      nm_sig = {ad_sum[EXT_W:2], ad_sum[1] | ad_sum[0]};
      nm_exp = {1'b0, al_exp} + XE_W'(1);
    end else begin
      sh     = (32'(lzc) < 32'(e_room)) ? 32'(lzc) : 32'(e_room);
      nm_sig = ad_sum[EXT_W-1:0] << sh;
      nm_exp = {1'b0, al_exp} - XE_W'(sh);
    end
    inexact = nm_sig[2] | nm_sig[1] | nm_sig[0];
    rnd_up  = nm_sig[2] & (nm_sig[1] | nm_sig[0] | nm_sig[3]);
    rnd     = {1'b0, nm_sig[EXT_W-1:3]} + (SIG_W+1)'(rnd_up);
    if (rnd[SIG_W]) begin
      e_fin    = nm_exp + XE_W'(1);
      frac_fin = rnd[MAN_W:1];
    end else if (rnd[SIG_W-1]) begin
      e_fin    = nm_exp;
      frac_fin = rnd[MAN_W-1:0];
    end else begin
      e_fin    = '0;
      frac_fin = rnd[MAN_W-1:0];
    end
    if (e_fin >= XE_W'(EXP_MAX)) begin
      nx_res   = {ad_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nx_flags = 3'b011;
    end else begin
      nx_res   = {ad_sign, e_fin[EXP_W-1:0], frac_fin};
      nx_flags = {2'b00, inexact};
    end
    if (sp_valid) begin
      nx_res   = sp_res;
      nx_flags = {sp_inv, 2'b00};
    end
  end

  // Busy reflects a request being accepted in IDLE, otherwise occupancy
  assign Busy = (state == S_IDLE) ? Start : 1'b1;

  // Sequencer, operand capture, stage registers and registered outputs
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      sub_q     <= 1'b0;
      tag_q     <= '0;
      al_sign   <= 1'b0;
      al_sub    <= 1'b0;
      al_exp    <= '0;
      al_big    <= '0;
      al_small  <= '0;
      sp_valid  <= 1'b0;
      sp_inv    <= 1'b0;
      sp_res    <= '0;
      ad_sum    <= '0;
      ad_sign   <= 1'b0;
      Result    <= '0;
      ResultTag <= '0;
      Flags     <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= (state == S_NORM);
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_a  <= Operand1;
            op_b  <= Operand2;
            sub_q <= Sub;
            tag_q <= Tag;
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          al_sign  <= nx_sign;
          al_sub   <= a_sign ^ b_sign;
          al_exp   <= nx_exp;
          al_big   <= {l_sig, 3'b000};
          al_small <= {s_top, |s_lost};
          sp_valid <= nx_sp_valid;
          sp_inv   <= nx_sp_inv;
          sp_res   <= nx_sp_res;
          state    <= S_ADD;
        end
        S_ADD: begin
          ad_sum  <= nx_sum;
          ad_sign <= nx_sum_sign;
          state   <= S_NORM;
        end
        S_NORM: begin
          Result    <= nx_res;
          ResultTag <= tag_q;
          Flags     <= nx_flags;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Scoreboard bench for fp_addsub_unit at default (binary32) parameters.
module tb_fp_addsub_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Sub;
  logic [3:0]  Tag;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result;
  logic [3:0]  ResultTag;
  logic [2:0]  Flags;
  logic        Busy;
  logic        Done;

  fp_addsub_unit dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Sub(Sub), .Tag(Tag),
    .Operand1(Operand1), .Operand2(Operand2), .Result(Result),
    .ResultTag(ResultTag), .Flags(Flags), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [2:0]  fl;
  } exp_t;

  typedef struct packed {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  vec_t vt [15] = '{
    '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000},
    '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000},
    '{1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 3'b000},
    '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b001},
    '{1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 3'b001},
    '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b011},
    '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100},
    '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000},
    '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000},
    '{1'b1, 32'h40000000, 32'h40400000, 32'hBF800000, 3'b000},
    '{1'b0, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b000},
    '{1'b0, 32'h007FFFFF, 32'h00000001, 32'h00800000, 3'b000},
    '{1'b0, 32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 3'b000},
    '{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 3'b000},
    '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100}
  };

  // Drive one request for the current cycle and record its expected outcome
  task automatic drive_op(input int idx, input logic [3:0] t);
    Start    = 1'b1;
    Sub      = vt[idx].sub;
    Tag      = t;
    Operand1 = vt[idx].a;
    Operand2 = vt[idx].b;
    sb.push_back('{res: vt[idx].res, tag: t, fl: vt[idx].fl});
  endtask

  task automatic drive_junk();
    Start    = 1'b1;
    Sub      = 1'($urandom);
    Tag      = 4'hF;
    Operand1 = $urandom;
    Operand2 = $urandom;
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1; Start = 1'b0; Sub = 1'b0; Tag = '0; Operand1 = '0; Operand2 = '0;
    repeat (3) @(negedge CLK);
    e = '{res: 32'h0, tag: 4'h0, fl: 3'b000};
    n_vec++;
    if ({Result, ResultTag, Flags} !== e || Done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got res=%h tag=%h fl=%b done=%b, want 0", Result, ResultTag, Flags, Done);
    end
    Start = 1'b1; #1;
    n_vec++;
    if (Busy !== 1'b1) begin n_err++; $display("FAIL reset_busy_start1: got %b want 1", Busy); end
    Start = 1'b0; #1;
    n_vec++;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_start0: got %b want 0", Busy); end
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_vectors();
    exp_t e;
    int   lat;
    bit   got;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      drive_op(i, 4'((i + 5) % 16));
      #1;
      n_vec++;
      if (Busy !== 1'b1) begin n_err++; $display("FAIL busy_on_start v%0d: got %b want 1", i, Busy); end
      lat = 0; got = 0;
      while (!got && lat < 20) begin
        @(negedge CLK);
        lat++;
        if (Done) got = 1;
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; Tag = 4'hF;
        if (lat < 4) begin
          #1;
          n_vec++;
          if (Busy !== 1'b1) begin n_err++; $display("FAIL busy_inflight v%0d c%0d: got %b want 1", i, lat, Busy); end
        end
      end
      n_vec++;
      if (!got || lat != 4) begin
        n_err++;
        $display("FAIL latency v%0d: got done=%0d at cycle %0d, want cycle 4", i, got, lat);
      end
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (Result !== e.res) begin n_err++; $display("FAIL result v%0d: got %h want %h", i, Result, e.res); end
        n_vec++;
        if (ResultTag !== e.tag) begin n_err++; $display("FAIL tag v%0d: got %h want %h", i, ResultTag, e.tag); end
        n_vec++;
        if (Flags !== e.fl) begin n_err++; $display("FAIL flags v%0d: got %b want %b", i, Flags, e.fl); end
      end else begin
        sb.delete();
      end
      @(negedge CLK);
      n_vec++;
      if (Done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width v%0d: got %b want 0", i, Done); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_done;
    int   pick [3] = '{0, 3, 9};
    for (int c = 0; c <= 13; c++) begin
      @(negedge CLK);
      exp_done = (c >= 4) && (c % 4 == 0) && (c <= 12);
      n_vec++;
      if (Done !== exp_done) begin n_err++; $display("FAIL b2b_done c%0d: got %b want %b", c, Done, exp_done); end
      if (Done) begin
        if (sb.size() == 0) begin
          n_err++; $display("FAIL b2b_unexpected c%0d: got res=%h want no result", c, Result);
        end else begin
          e = sb.pop_front();
          n_vec++;
          if ({Result, ResultTag, Flags} !== e) begin
            n_err++;
            $display("FAIL b2b_result c%0d: got %h/%h/%b want %h/%h/%b", c, Result, ResultTag, Flags, e.res, e.tag, e.fl);
          end
        end
      end
      if (c % 4 == 0 && c <= 8) drive_op(pick[c/4], 4'(c/4 + 1));
      else if (c < 12)          drive_junk();
      else                      Start = 1'b0;
    end
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL b2b_leftover: got %0d pending want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    bit   got;
    @(negedge CLK);
    drive_op(0, 4'h9);
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    sb.delete();
    #1;
    n_vec++;
    if ({Result, ResultTag, Flags, Done, Busy} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got res=%h tag=%h fl=%b done=%b busy=%b want 0", Result, ResultTag, Flags, Done, Busy);
    end
    @(negedge CLK);
    Reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      n_vec++;
      if (Done !== 1'b0 || Result !== 32'h0) begin
        n_err++; $display("FAIL abort_no_done c%0d: got done=%b res=%h want 0/0", c, Done, Result);
      end
    end
    drive_op(5, 4'h6);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (Done) got = 1;
      Start = 1'b0;
    end
    n_vec++;
    if (!got || lat != 4) begin n_err++; $display("FAIL abort_next_latency: got done=%0d at cycle %0d want cycle 4", got, lat); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({Result, ResultTag, Flags} !== e) begin
        n_err++;
        $display("FAIL abort_next_result: got %h/%h/%b want %h/%h/%b", Result, ResultTag, Flags, e.res, e.tag, e.fl);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
